// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//   Registered ALU with a valid/ready handshake on the command side and on the
//   result side. Single-cycle ops (PASS_B, ADD, SUB, AND, OR, XOR) produce a
//   registered result one cycle after acceptance. MUL (cntrl 3'b111, when
//   MUL_EN=1) is an iterative shift-and-add multiply that takes WIDTH cycles.
//   The block sits between the register-file read stage and the
//   writeback/flag-update stage.
//
// Ports
//   clk        : system clock, all state on the rising edge
//   reset      : asynchronous, active-high reset
//   in_valid   : command valid (A, B, cntrl)
//   in_ready   : block accepts a command this cycle
//   A, B       : operands, WIDTH bits
//   cntrl      : 000/001 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR,
//                111 MUL
//   out_valid  : result and flags valid
//   out_ready  : consumer takes the result this cycle
//   result     : registered result
//   negative   : result[WIDTH-1]
//   zero       : result == 0
//   overflow   : signed overflow (ADD/SUB only)
//   carry_out  : carry out of the MSB (ADD/SUB only; 1 = no borrow on SUB)
//   busy       : MUL iteration in progress
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_last;
  logic [WIDTH+1:0] w_alu;
  logic [WIDTH-1:0] w_acc_nxt;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_result;
  logic             r_negative;
  logic             r_zero;
  logic             r_overflow;
  logic             r_carry_out;

  // Single-cycle ALU. Returns {overflow, carry_out, result}.
  // SUB reuses the adder as A + ~B + 1; overflow is carry into the MSB XOR
  // carry out of the MSB.
  function automatic logic [WIDTH+1:0] alu_eval(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] b_eff;
    logic             c_in_msb;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             cout;
    res  = '0;
    ovf  = 1'b0;
    cout = 1'b0;
    case (op)
      3'b010, 3'b011: begin
        b_eff    = op[0] ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[0]};
        c_in_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
        res      = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        ovf      = c_in_msb ^ sum[WIDTH];
      end
      3'b100:  res = a & b;
      3'b101:  res = a | b;
      3'b110:  res = a ^ b;
      // Only reached for MUL when the multiplier is compiled out.
      3'b111:  res = '0;
      default: res = b;
    endcase
    return {ovf, cout, res};
  endfunction

  assign w_is_mul   = MUL_EN && (cntrl == 3'b111);
  assign w_alu      = alu_eval(cntrl, A, B);
  assign w_mul_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_nxt  = r_acc + (r_mcand[0] ? r_mplier : '0);
  assign w_accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        if (w_mul_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // The result drains on the same edge a new command is taken.
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_state_nxt = w_is_mul ? S_MUL : S_DONE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture / iterate / register result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_mplier    <= '0;
      r_mcand     <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_negative  <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_acc    <= '0;
        r_mplier <= A;
        r_mcand  <= B;
        r_cnt    <= '0;
      end else begin
        r_result    <= w_alu[WIDTH-1:0];
        r_negative  <= w_alu[WIDTH-1];
        r_zero      <= (w_alu[WIDTH-1:0] == '0);
        r_carry_out <= w_alu[WIDTH];
        r_overflow  <= w_alu[WIDTH+1];
      end
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= r_mplier << 1;
      r_mcand  <= r_mcand >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      // The last partial product folds straight into the output register.
      if (w_mul_last) begin
        r_result    <= w_acc_nxt;
        r_negative  <= w_acc_nxt[WIDTH-1];
        r_zero      <= (w_acc_nxt == '0);
        r_carry_out <= 1'b0;
        r_overflow  <= 1'b0;
      end
    end
  end

  assign result    = r_result;
  assign negative  = r_negative;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign carry_out = r_carry_out;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//   Directed bench for alu_seq (WIDTH=64, MUL_EN=1). Stimulus pushes the
//   hand-computed expected response into a scoreboard queue on each accepted
//   command; a monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 64;

  localparam logic [2:0] OP_PASS0 = 3'b000;
  localparam logic [2:0] OP_PASS1 = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_XOR   = 3'b110;
  localparam logic [2:0] OP_MUL   = 3'b111;

  localparam logic [W-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINS = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] MAXS = 64'h7FFF_FFFF_FFFF_FFFF;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   cntrl;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;
  logic         busy;

  // flags packed as {negative, zero, overflow, carry_out}
  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   f;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cntrl     (cntrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge. Holds the command until accepted, then
  // records the expected response. Returns the number of stalled cycles.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] er, input logic [3:0] ef, output int stalls);
    exp_t e;
    stalls   = 0;
    in_valid = 1'b1;
    cntrl    = op;
    A        = a;
    B        = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 200) break;
    end
    if (stalls > 200) begin
      chk("send_timeout", 64'(stalls), 64'd0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.res = er;
      e.f   = ef;
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // MUL with latency/busy checks; optionally presents a command mid-MUL.
  task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [3:0] ef, input bit inject);
    int st;
    int k;
    int bad_busy;
    int bad_rdy;
    send(OP_MUL, a, b, er, ef, st);
    k        = 0;
    bad_busy = 0;
    bad_rdy  = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      if (!busy) bad_busy++;
      if (inject && k >= 10 && k < 15 && in_ready) bad_rdy++;
      if (inject && k == 9) begin
        in_valid = 1'b1;
        cntrl    = OP_PASS0;
        A        = 64'h1111;
        B        = 64'hDEAD;
      end
      if (inject && k == 14) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("mul_latency", 64'(k), 64'd65);
    chk("mul_busy_cycles", 64'(bad_busy), 64'd0);
    if (inject) chk("mul_in_ready_low", 64'(bad_rdy), 64'd0);
    sync();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", result, 64'hx);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags", 64'({negative, zero, overflow, carry_out}), 64'(e.f));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  logic [W-1:0] ta [8];
  logic [W-1:0] tbv[8];
  logic [W-1:0] te [8];
  logic [3:0]   tf [8];

  initial begin
    int st;
    int stall_total;
    int bad;

    ta[0] = 64'd1;  tbv[0] = 64'd100;  te[0] = 64'd101;              tf[0] = 4'b0000;
    ta[1] = ALL1;   tbv[1] = 64'd1;    te[1] = 64'd0;                tf[1] = 4'b0101;
    ta[2] = MINS;   tbv[2] = MINS;     te[2] = 64'd0;                tf[2] = 4'b0111;
    ta[3] = 64'd10; tbv[3] = 64'd20;   te[3] = 64'd30;               tf[3] = 4'b0000;
    ta[4] = ALL1;   tbv[4] = ALL1;     te[4] = 64'hFFFF_FFFF_FFFF_FFFE; tf[4] = 4'b1001;
    ta[5] = MAXS;   tbv[5] = MAXS;     te[5] = 64'hFFFF_FFFF_FFFF_FFFE; tf[5] = 4'b1010;
    ta[6] = 64'd0;  tbv[6] = 64'd0;    te[6] = 64'd0;                tf[6] = 4'b0100;
    ta[7] = 64'd1234; tbv[7] = 64'd4321; te[7] = 64'd5555;           tf[7] = 4'b0000;

    reset     = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    cntrl     = OP_PASS0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'({negative, zero, overflow, carry_out}), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    sync();

    // ADD signed overflow, latency 1
    send(OP_ADD, MAXS, 64'd1, MINS, 4'b1010, st);
    @(negedge clk);
    chk("add_latency", 64'(out_valid), 64'd1);
    sync();

    // SUB and logic ops, back to back
    send(OP_SUB, 64'd5, 64'd5, 64'd0, 4'b0101, st);
    send(OP_SUB, 64'd0, 64'd1, ALL1, 4'b1000, st);
    send(OP_SUB, MINS, 64'd1, MAXS, 4'b0011, st);
    send(OP_PASS1, 64'd7, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b1000, st);
    send(OP_PASS0, 64'd5, 64'd0, 64'd0, 4'b0100, st);
    send(OP_OR, 64'h0F, 64'hF0, 64'hFF, 4'b0000, st);
    @(negedge clk);
    sync();

    // MUL
    mul_run(64'd12345, 64'd1000, 64'd12345000, 4'b0000, 1'b1);
    mul_run(64'd7, 64'd0, 64'd0, 4'b0100, 1'b0);
    mul_run(ALL1, ALL1, 64'd1, 4'b0000, 1'b0);

    // Backpressure with a queued AND
    out_ready = 1'b0;
    send(OP_XOR, 64'hF0F0, 64'h0FF0, 64'hFF00, 4'b0000, st);
    in_valid = 1'b1;
    cntrl    = OP_AND;
    A        = 64'hFF0F;
    B        = 64'h0FF0;
    bad      = 0;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || result !== 64'hFF00 || in_ready) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    sync();
    out_ready = 1'b1;
    send(OP_AND, 64'hFF0F, 64'h0FF0, 64'h0F00, 4'b0000, st);
    chk("bp_and_stalls", 64'(st), 64'd0);
    @(negedge clk);
    chk("bp_same_cycle", {63'd0, out_valid} + (result << 1), {63'd0, 1'b1} + (64'h0F00 << 1));
    sync();

    // Stream of 8 ADDs
    stall_total = 0;
    for (int i = 0; i < 8; i++) begin
      send(OP_ADD, ta[i], tbv[i], te[i], tf[i], st);
      stall_total += st;
    end
    chk("stream_stalls", 64'(stall_total), 64'd0);
    @(negedge clk);
    chk("stream_last_valid", 64'(out_valid), 64'd1);
    sync();

    // Reset mid-MUL
    send(OP_MUL, 64'd3, 64'd5, 64'd15, 4'b0000, st);
    repeat (30) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_flags", 64'({negative, zero, overflow, carry_out}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    sync();
    send(OP_ADD, 64'd2, 64'd3, 64'd5, 4'b0000, st);
    repeat (80) @(negedge clk);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
